dut_seq_ctrl: RTL and testbench

//  Sequencer/master for the dut block's enable/ready method interfaces (cfg, len, din, dout).

---
 rtl/dut_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 tb/tb_dut_seq_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dut_seq_ctrl.sv
// dut_seq_ctrl: job sequencer that drives the dut's cfg, len, din and dout
// method interfaces. For each accepted job it writes a config word, reads
// back a status word, programs the input length, then streams bytes from a
// source into din while draining dout into a sink. Every job ends with a
// one-cycle done pulse; err marks an abort caused by the stall watchdog.
//
// Handshake semantics (all interfaces):
//   Host command : a job transfers on a cycle where cmd_valid && cmd_ready.
//                  cmd_ready is high only in IDLE.
//   Source       : a byte transfers on a cycle where src_valid && src_ready;
//                  src_ready is the din method enable, so a byte is only
//                  taken when the dut can accept it.
//   Sink         : a byte transfers on a cycle where snk_valid && snk_ready;
//                  snk_valid is the dout method enable, so a byte is only
//                  pulled from the dut when the sink can take it.
//   dut methods  : *_en is combinational from state and *_rdy and is never
//                  high while *_rdy is low. The method fires in any cycle
//                  with *_en high. Read data (cfg_data_out) is sampled in
//                  that same cycle.
module dut_seq_ctrl #(
    parameter logic [7:0]  CFG_WR_ADDR = 8'h00,
    parameter logic [7:0]  CFG_RD_ADDR = 8'h04,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        CLK,
    input  logic        RST,

    // host job command
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_in_len,
    input  logic [7:0]  cmd_out_len,
    input  logic [31:0] cmd_cfg_word,

    // byte source feeding din
    input  logic        src_valid,
    input  logic [7:0]  src_data,
    output logic        src_ready,

    // byte sink fed from dout
    output logic        snk_valid,
    output logic [7:0]  snk_data,
    input  logic        snk_ready,

    // dut din method
    output logic        din_en,
    output logic [7:0]  din_value,
    input  logic        din_rdy,

    // dut dout method
    output logic        dout_en,
    input  logic [7:0]  dout_value,
    input  logic        dout_rdy,

    // dut len method
    output logic        len_en,
    output logic [7:0]  len_value,
    input  logic        len_rdy,

    // dut cfg method (op 1 = write, 0 = read)
    output logic        cfg_en,
    output logic        cfg_op,
    output logic [7:0]  cfg_address,
    output logic [31:0] cfg_data_in,
    input  logic [31:0] cfg_data_out,
    input  logic        cfg_rdy,

    // job status
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] status_word,

    // current FSM state, for observation only
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CFG_WR = 3'd1,
        S_CFG_RD = 3'd2,
        S_LEN    = 3'd3,
        S_STREAM = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // Watchdog width: it only has to reach TIMEOUT_CYC-1.
    localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    state_t state_q;
    state_t state_d;

    // job parameters latched at accept
    logic [7:0]  in_len_q;
    logic [7:0]  out_len_q;
    logic [31:0] cfg_word_q;

    // stream progress counters, bounded by the job lengths
    logic [7:0]  in_cnt_q;
    logic [7:0]  out_cnt_q;
    logic [7:0]  in_cnt_d;
    logic [7:0]  out_cnt_d;

    // stall watchdog
    logic [WD_W-1:0] wd_q;
    logic            wd_active;
    logic            any_fire;
    logic            timeout_hit;

    logic [31:0] status_q;
    logic        cmd_accept;

    assign cmd_accept = (state_q == S_IDLE) && cmd_valid;

    // The watchdog runs only while a job is actually waiting on the dut.
    assign wd_active = (state_q != S_IDLE) && (state_q != S_DONE);

    // Next-state and method enables, derived from state and the rdy inputs.
    always_comb begin
        state_d     = state_q;
        cfg_en      = 1'b0;
        cfg_op      = 1'b0;
        cfg_address = 8'h00;
        cfg_data_in = 32'h0000_0000;
        len_en      = 1'b0;
        din_en      = 1'b0;
        dout_en     = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        any_fire    = 1'b0;
        timeout_hit = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_CFG_WR;
                end
            end

            S_CFG_WR: begin
                cfg_en      = cfg_rdy;
                cfg_op      = 1'b1;
                cfg_address = CFG_WR_ADDR;
                cfg_data_in = cfg_word_q;
                if (cfg_rdy) begin
                    state_d = S_CFG_RD;
                end
            end

            S_CFG_RD: begin
                cfg_en      = cfg_rdy;
                cfg_op      = 1'b0;
                cfg_address = CFG_RD_ADDR;
                if (cfg_rdy) begin
                    state_d = S_LEN;
                end
            end

            S_LEN: begin
                len_en = len_rdy;
                if (len_rdy) begin
                    state_d = S_STREAM;
                end
            end

            S_STREAM: begin
                din_en    = src_valid && din_rdy && (in_cnt_q < in_len_q);
                dout_en   = dout_rdy && snk_ready && (out_cnt_q < out_len_q);
                in_cnt_d  = in_cnt_q + {7'd0, din_en};
                out_cnt_d = out_cnt_q + {7'd0, dout_en};
                // Final fires in this cycle already count toward completion.
                if ((in_cnt_d == in_len_q) && (out_cnt_d == out_len_q)) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        any_fire = cfg_en || len_en || din_en || dout_en;

        // A full window without any method firing aborts the job; the abort
        // is reported in the stalled cycle itself and the FSM goes idle.
        if (wd_active && !any_fire && (wd_q == WD_LAST)) begin
            timeout_hit = 1'b1;
            done        = 1'b1;
            err         = 1'b1;
            state_d     = S_IDLE;
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the job parameters when a command is accepted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            in_len_q   <= 8'd0;
            out_len_q  <= 8'd0;
            cfg_word_q <= 32'h0000_0000;
        end else if (cmd_accept) begin
            in_len_q   <= cmd_in_len;
            out_len_q  <= cmd_out_len;
            cfg_word_q <= cmd_cfg_word;
        end
    end

    // Byte counters: cleared per job, advanced by din/dout fires in STREAM.
    always_ff @(posedge CLK) begin
        if (RST) begin
            in_cnt_q  <= 8'd0;
            out_cnt_q <= 8'd0;
        end else if (cmd_accept) begin
            in_cnt_q  <= 8'd0;
            out_cnt_q <= 8'd0;
        end else if (state_q == S_STREAM) begin
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    // Watchdog: restarts on every state change and every method fire.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wd_q <= '0;
        end else if ((state_d != state_q) || any_fire || !wd_active) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + WD_W'(1);
        end
    end

    // Capture the status word on the cfg read fire; held otherwise.
    always_ff @(posedge CLK) begin
        if (RST) begin
            status_q <= 32'h0000_0000;
        end else if ((state_q == S_CFG_RD) && cfg_en) begin
            status_q <= cfg_data_out;
        end
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign len_value   = in_len_q;
    assign din_value   = src_data;
    assign src_ready   = din_en;
    assign snk_valid   = dout_en;
    assign snk_data    = dout_value;
    assign status_word = status_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_dut_seq_ctrl.sv
// Directed bench for dut_seq_ctrl: reset, nominal job, backpressure,
// zero length, watchdog abort and reset in the middle of a stream.
module tb_dut_seq_ctrl;

    localparam int unsigned TO = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_in_len;
    logic [7:0]  cmd_out_len;
    logic [31:0] cmd_cfg_word;
    logic        src_valid;
    logic [7:0]  src_data;
    logic        src_ready;
    logic        snk_valid;
    logic [7:0]  snk_data;
    logic        snk_ready;
    logic        din_en;
    logic [7:0]  din_value;
    logic        din_rdy;
    logic        dout_en;
    logic [7:0]  dout_value;
    logic        dout_rdy;
    logic        len_en;
    logic [7:0]  len_value;
    logic        len_rdy;
    logic        cfg_en;
    logic        cfg_op;
    logic [7:0]  cfg_address;
    logic [31:0] cfg_data_in;
    logic [31:0] cfg_data_out;
    logic        cfg_rdy;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] status_word;
    logic [2:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    // scoreboard
    logic [7:0]  din_exp_q[$];
    logic [7:0]  snk_exp_q[$];
    logic [7:0]  src_mem[0:15];
    logic [7:0]  dout_mem[0:15];
    logic [3:0]  src_idx;
    logic [3:0]  dout_idx;
    logic [31:0] exp_cfg_word;
    int          din_seen;
    int          dout_seen;
    int          cfg_wr_seen;
    int          cfg_rd_seen;
    int          len_seen;
    int          done_seen;
    logic [7:0]  len_val_seen;

    int   done_n;
    logic err_v;

    // clock
    always #5 CLK = ~CLK;

    dut_seq_ctrl #(
        .CFG_WR_ADDR (8'h00),
        .CFG_RD_ADDR (8'h04),
        .TIMEOUT_CYC (TO)
    ) u_dut (
        .CLK          (CLK),
        .RST          (RST),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_in_len   (cmd_in_len),
        .cmd_out_len  (cmd_out_len),
        .cmd_cfg_word (cmd_cfg_word),
        .src_valid    (src_valid),
        .src_data     (src_data),
        .src_ready    (src_ready),
        .snk_valid    (snk_valid),
        .snk_data     (snk_data),
        .snk_ready    (snk_ready),
        .din_en       (din_en),
        .din_value    (din_value),
        .din_rdy      (din_rdy),
        .dout_en      (dout_en),
        .dout_value   (dout_value),
        .dout_rdy     (dout_rdy),
        .len_en       (len_en),
        .len_value    (len_value),
        .len_rdy      (len_rdy),
        .cfg_en       (cfg_en),
        .cfg_op       (cfg_op),
        .cfg_address  (cfg_address),
        .cfg_data_in  (cfg_data_in),
        .cfg_data_out (cfg_data_out),
        .cfg_rdy      (cfg_rdy),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .status_word  (status_word),
        .dbg_state    (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Per-cycle observation of method fires, called at the sample point.
    task automatic monitor();
        logic [7:0] e;
        if (cfg_en) begin
            check("cfg_en_rdy", {31'd0, cfg_rdy}, 32'd1);
            if (cfg_op) begin
                check("cfg_wr_addr", {24'd0, cfg_address}, 32'h00);
                check("cfg_wr_data", cfg_data_in, exp_cfg_word);
                check("cfg_wr_before_rd", cfg_rd_seen, 0);
                cfg_wr_seen++;
            end else begin
                check("cfg_rd_addr", {24'd0, cfg_address}, 32'h04);
                check("cfg_rd_after_wr", cfg_wr_seen, 1);
                cfg_rd_seen++;
            end
        end
        if (len_en) begin
            check("len_en_rdy", {31'd0, len_rdy}, 32'd1);
            check("len_after_cfg_rd", cfg_rd_seen, 1);
            len_seen++;
            len_val_seen = len_value;
        end
        if (din_en) begin
            check("din_en_rdy", {31'd0, din_rdy & src_valid}, 32'd1);
            check("src_ready_eq_din_en", {31'd0, src_ready}, 32'd1);
            check("din_byte_expected", {31'd0, din_exp_q.size() > 0}, 32'd1);
            if (din_exp_q.size() > 0) begin
                e = din_exp_q.pop_front();
                check("din_value", {24'd0, din_value}, {24'd0, e});
            end
            din_seen++;
        end
        if (dout_en) begin
            check("dout_en_rdy", {31'd0, dout_rdy & snk_ready}, 32'd1);
            check("snk_valid_eq_dout_en", {31'd0, snk_valid}, 32'd1);
            check("snk_byte_expected", {31'd0, snk_exp_q.size() > 0}, 32'd1);
            if (snk_exp_q.size() > 0) begin
                e = snk_exp_q.pop_front();
                check("snk_data", {24'd0, snk_data}, {24'd0, e});
            end
            dout_seen++;
        end
        if (done === 1'b1) begin
            done_seen++;
        end
    endtask

    // Advance one clock; source/sink models step on the bytes that fired.
    task automatic tick();
        logic df;
        logic of;
        df = din_en;
        of = dout_en;
        @(posedge CLK);
        #1;
        if (df) src_idx = src_idx + 4'd1;
        if (of) dout_idx = dout_idx + 4'd1;
        src_data   = src_mem[src_idx];
        dout_value = dout_mem[dout_idx];
    endtask

    // Drive one job. mode 0: all rdy high; 1: din_rdy/snk_ready toggle;
    // 2: cfg_rdy held low after accept; 3: reset asserted at n==5.
    // done_n = clock edges from the accept edge to the done cycle (-1 if none).
    task automatic run_job(input logic [7:0] in_len, input logic [7:0] out_len,
                           input logic [31:0] cfg_word, input logic [31:0] rd_val,
                           input logic [7:0] src_base, input logic [7:0] dout_base,
                           input int mode, output int dn, output logic ev);
        for (int i = 0; i < 16; i++) begin
            src_mem[i]  = src_base + 8'(i);
            dout_mem[i] = dout_base + 8'(i);
        end
        din_exp_q.delete();
        snk_exp_q.delete();
        for (int i = 0; i < int'(in_len); i++) din_exp_q.push_back(src_mem[i]);
        for (int i = 0; i < int'(out_len); i++) snk_exp_q.push_back(dout_mem[i]);
        src_idx      = 4'd0;
        dout_idx     = 4'd0;
        src_data     = src_mem[0];
        dout_value   = dout_mem[0];
        din_seen     = 0;
        dout_seen    = 0;
        cfg_wr_seen  = 0;
        cfg_rd_seen  = 0;
        len_seen     = 0;
        done_seen    = 0;
        len_val_seen = 8'hEE;
        exp_cfg_word = cfg_word;
        cfg_data_out = rd_val;
        cfg_rdy      = 1'b1;
        len_rdy      = 1'b1;
        din_rdy      = 1'b1;
        dout_rdy     = 1'b1;
        snk_ready    = 1'b1;
        src_valid    = 1'b1;
        cmd_valid    = 1'b1;
        cmd_in_len   = in_len;
        cmd_out_len  = out_len;
        cmd_cfg_word = cfg_word;
        #2;
        check("cmd_ready_at_accept", {31'd0, cmd_ready}, 32'd1);
        monitor();
        tick();
        // scramble the command inputs: the job must run on latched values
        cmd_valid    = 1'b0;
        cmd_in_len   = ~in_len;
        cmd_out_len  = ~out_len;
        cmd_cfg_word = ~cfg_word;
        if (mode == 2) cfg_rdy = 1'b0;
        dn = -1;
        ev = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (mode == 1) begin
                din_rdy   = n[0];
                snk_ready = ~n[0];
            end
            if (mode == 3 && n == 5) begin
                RST       = 1'b1;
                src_valid = 1'b0;
                snk_ready = 1'b0;
            end
            #2;
            monitor();
            if (done === 1'b1) begin
                dn = n;
                ev = err;
            end
            tick();
            if (mode == 3 && n == 5) begin
                RST = 1'b0;
                break;
            end
            if (dn >= 0) break;
        end
    endtask

    initial begin
        RST          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_in_len   = 8'd0;
        cmd_out_len  = 8'd0;
        cmd_cfg_word = 32'd0;
        src_valid    = 1'b0;
        src_data     = 8'd0;
        snk_ready    = 1'b1;
        din_rdy      = 1'b1;
        dout_rdy     = 1'b1;
        dout_value   = 8'd0;
        len_rdy      = 1'b1;
        cfg_rdy      = 1'b1;
        cfg_data_out = 32'hDEAD_BEEF;
        src_idx      = 4'd0;
        dout_idx     = 4'd0;

        // 1: reset held three cycles
        repeat (3) @(posedge CLK);
        #3;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cfg_en", {31'd0, cfg_en}, 32'd0);
        check("rst_len_en", {31'd0, len_en}, 32'd0);
        check("rst_din_en", {31'd0, din_en}, 32'd0);
        check("rst_dout_en", {31'd0, dout_en}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_status", status_word, 32'd0);
        check("rst_state", {29'd0, dbg_state}, 32'd0);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // 2: nominal 4/4 job
        run_job(8'd4, 8'd4, 32'hA5A5_0001, 32'h0000_1234, 8'h01, 8'hC0, 0, done_n, err_v);
        check("nom_done_cycle", done_n, 7);
        check("nom_err", {31'd0, err_v}, 32'd0);
        check("nom_status", status_word, 32'h0000_1234);
        check("nom_len_value", {24'd0, len_val_seen}, 32'd4);
        check("nom_cfg_wr_count", cfg_wr_seen, 1);
        check("nom_cfg_rd_count", cfg_rd_seen, 1);
        check("nom_din_count", din_seen, 4);
        check("nom_dout_count", dout_seen, 4);
        check("nom_din_q_empty", din_exp_q.size(), 0);
        check("nom_snk_q_empty", snk_exp_q.size(), 0);

        // 3: backpressure on din and sink, 8/8
        run_job(8'd8, 8'd8, 32'h0000_0033, 32'hCAFE_0003, 8'h30, 8'h80, 1, done_n, err_v);
        check("bp_done_cycle", done_n, 19);
        check("bp_err", {31'd0, err_v}, 32'd0);
        check("bp_din_count", din_seen, 8);
        check("bp_dout_count", dout_seen, 8);
        check("bp_din_q_empty", din_exp_q.size(), 0);
        check("bp_snk_q_empty", snk_exp_q.size(), 0);
        check("bp_status", status_word, 32'hCAFE_0003);

        // 4: zero lengths, accepted back-to-back right after the last done
        run_job(8'd0, 8'd0, 32'h0000_0044, 32'h0000_0BAD, 8'h50, 8'h60, 0, done_n, err_v);
        check("zero_done_cycle", done_n, 4);
        check("zero_err", {31'd0, err_v}, 32'd0);
        check("zero_len_written", len_seen, 1);
        check("zero_len_value", {24'd0, len_val_seen}, 32'd0);
        check("zero_din_count", din_seen, 0);
        check("zero_dout_count", dout_seen, 0);

        // 5: cfg stall until the watchdog aborts
        run_job(8'd3, 8'd3, 32'h0000_0055, 32'h0000_5555, 8'h70, 8'h90, 2, done_n, err_v);
        check("to_done_cycle", done_n, 15);
        check("to_err", {31'd0, err_v}, 32'd1);
        check("to_cfg_count", cfg_wr_seen, 0);
        check("to_done_pulses", done_seen, 1);
        #2;
        check("to_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
        check("to_busy_after", {31'd0, busy}, 32'd0);
        check("to_done_after", {31'd0, done}, 32'd0);
        check("to_status_held", status_word, 32'h0000_0BAD);
        @(posedge CLK);
        #1;

        // 6: reset after 2 of 5 bytes, then a clean job
        run_job(8'd5, 8'd5, 32'h0000_0066, 32'h0000_6666, 8'hA0, 8'hB0, 3, done_n, err_v);
        check("mid_no_done", done_seen, 0);
        check("mid_din_count", din_seen, 2);
        check("mid_dout_count", dout_seen, 2);
        #2;
        check("mid_busy", {31'd0, busy}, 32'd0);
        check("mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("mid_done", {31'd0, done}, 32'd0);
        check("mid_status_cleared", status_word, 32'd0);
        @(posedge CLK);
        #1;
        run_job(8'd3, 8'd2, 32'h0000_0077, 32'h0000_600D, 8'hD0, 8'hE0, 0, done_n, err_v);
        check("post_done_cycle", done_n, 6);
        check("post_err", {31'd0, err_v}, 32'd0);
        check("post_din_count", din_seen, 3);
        check("post_dout_count", dout_seen, 2);
        check("post_din_q_empty", din_exp_q.size(), 0);
        check("post_snk_q_empty", snk_exp_q.size(), 0);
        check("post_status", status_word, 32'h0000_600D);

        // report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // absolute time guard
    initial begin
        #200000;
        $display("FAIL sim_time_guard observed=expired expected=finished");
        $fatal(1, "time guard expired");
    end

endmodule
